// File: rtl/io_pkg.sv
// Shared constants, select encoding and word-offset decode for the I/O responder page.
package io_pkg;

    localparam logic [21:0] IO_PAGE_TAG   = 22'h3FFFFF;
    localparam logic [9:0]  IO_LED        = 10'h000;
    localparam logic [9:0]  IO_SW         = 10'h010;
    localparam logic [9:0]  IO_BTN        = 10'h020;
    localparam logic [9:0]  IO_CNT        = 10'h030;
    localparam logic [9:0]  IO_CLR        = 10'h040;
    localparam int          IO_DEB_CYCLES = 20000;
    localparam int          IO_NUM_SW     = 24;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_CNT,
        SEL_CLR
    } io_sel_t;

    // Decode on the word index only, so byte/halfword offsets alias their word.
    function automatic io_sel_t io_decode(input logic [7:0] word);
        case (word)
            IO_LED[9:2]: return SEL_LED;
            IO_SW[9:2]:  return SEL_SW;
            IO_BTN[9:2]: return SEL_BTN;
            IO_CNT[9:2]: return SEL_CNT;
            IO_CLR[9:2]: return SEL_CLR;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One raw asynchronous input: 2-flop synchronizer followed by a stable-count debouncer.
module io_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive cycles the synchronized value has differed from dout.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O page: LED register, debounced switches, sticky button flag and cycle counter.
module io_responder
    import io_pkg::*;
#(
    parameter int DEB_CYCLES = IO_DEB_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [9:0]  addr_low,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [23:0] switch_in,
    input  logic        button_in,
    output logic [23:0] led_out
);

    logic [IO_NUM_SW:0] raw;
    logic [IO_NUM_SW:0] deb;
    logic [23:0]        sw_deb;
    logic               btn_deb;
    logic               btn_prev;
    logic               press_flag;
    logic [23:0]        led_q;
    logic [31:0]        cycle_cnt;
    io_sel_t            sel;
    logic               wr_led, wr_clr, rd_btn, btn_rise;
    logic               unused_bits;

    assign raw     = {button_in, switch_in};
    assign sw_deb  = deb[IO_NUM_SW-1:0];
    assign btn_deb = deb[IO_NUM_SW];

    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [IO_NUM_SW:0] (
        .clock (clock),
        .reset (reset),
        .din   (raw),
        .dout  (deb)
    );

    assign sel         = io_decode(addr_low[9:2]);
    assign wr_led      = IOWrite && (sel == SEL_LED);
    assign wr_clr      = IOWrite && (sel == SEL_CLR);
    assign rd_btn      = IORead  && (sel == SEL_BTN);
    assign btn_rise    = btn_deb && !btn_prev;
    assign led_out     = led_q;
    assign unused_bits = ^{addr_low[1:0], wdata[31:24]};

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q      <= '0;
            cycle_cnt  <= '0;
            btn_prev   <= 1'b0;
            press_flag <= 1'b0;
        end else begin
            if (wr_led) led_q <= wdata[23:0];
            cycle_cnt <= wr_clr ? 32'h0 : cycle_cnt + 32'h1;
            btn_prev  <= btn_deb;
            // A new press outranks a clearing read landing on the same edge.
            if (btn_rise)    press_flag <= 1'b1;
            else if (rd_btn) press_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (IORead) begin
            case (sel)
                SEL_LED: rdata = {8'h0, led_q};
                SEL_SW:  rdata = {8'h0, sw_deb};
                SEL_BTN: rdata = {31'h0, press_flag};
                SEL_CNT: rdata = cycle_cnt;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with a short debounce window.
module tb_io_responder;
    import io_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        IORead, IOWrite;
    logic [9:0]  addr_low;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [23:0] switch_in;
    logic        button_in;
    logic [23:0] led_out;

    int pass_cnt = 0;
    int total    = 0;

    io_responder #(.DEB_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .IORead    (IORead),
        .IOWrite   (IOWrite),
        .addr_low  (addr_low),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch_in (switch_in),
        .button_in (button_in),
        .led_out   (led_out)
    );

    always #5 clock = ~clock;

    // Drive a bus cycle at the falling edge; checks follow 1ns later, well before the next rising edge.
    task automatic step(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        IORead = rd; IOWrite = wr; addr_low = a; wdata = d;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_LED, 32'h0);
        total++; if (led_out !== 24'h0) $display("FAIL reset_led: got %h want 000000", led_out); else pass_cnt++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        reset = 1'b0;
        total++; if (rdata !== 32'h0) $display("FAIL reset_cnt: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL cnt_inc: got %h want 00000001", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL reset_btn: got %h want 00000000", rdata); else pass_cnt++;
    endtask

    task automatic test_led();
        step(1'b0, 1'b1, IO_LED, 32'hFFA5A5A5);
        total++; if (led_out !== 24'h0) $display("FAIL led_pre: got %h want 000000", led_out); else pass_cnt++;
        step(1'b1, 1'b0, IO_LED, 32'h0);
        total++; if (led_out !== 24'hA5A5A5) $display("FAIL led_out: got %h want a5a5a5", led_out); else pass_cnt++;
        total++; if (rdata !== 32'h00A5A5A5) $display("FAIL led_rd: got %h want 00a5a5a5", rdata); else pass_cnt++;
    endtask

    task automatic test_rw_same();
        step(1'b1, 1'b1, IO_LED, 32'h00123456);
        total++; if (rdata !== 32'h00A5A5A5) $display("FAIL rw_pre: got %h want 00a5a5a5", rdata); else pass_cnt++;
        step(1'b1, 1'b0, 10'h001, 32'h0);
        total++; if (rdata !== 32'h00123456) $display("FAIL rw_post_byteoff: got %h want 00123456", rdata); else pass_cnt++;
        total++; if (led_out !== 24'h123456) $display("FAIL rw_led: got %h want 123456", led_out); else pass_cnt++;
    endtask

    task automatic test_switch();
        step(1'b0, 1'b0, 10'h0, 32'h0);
        switch_in = 24'h1;
        repeat (3) step(1'b0, 1'b0, 10'h0, 32'h0);
        switch_in = 24'h0;
        repeat (6) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL sw_glitch: got %h want 00000000", rdata); else pass_cnt++;
        switch_in = 24'h1;
        repeat (4) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL sw_early: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL sw_stable: got %h want 00000001", rdata); else pass_cnt++;
    endtask

    task automatic test_button();
        step(1'b0, 1'b0, 10'h0, 32'h0);
        button_in = 1'b1;
        repeat (6) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL btn_first: got %h want 00000001", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL btn_clear: got %h want 00000000", rdata); else pass_cnt++;
        button_in = 1'b0;
        repeat (8) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL btn_fall: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b0, 1'b0, 10'h0, 32'h0);
        button_in = 1'b1;
        repeat (5) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL btn_coinc_rd: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL btn_coinc_set: got %h want 00000001", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL btn_coinc_clr: got %h want 00000000", rdata); else pass_cnt++;
    endtask

    task automatic test_counter();
        step(1'b0, 1'b0, 10'h0, 32'h0);
        force dut.cycle_cnt = 32'hFFFFFFFE;
        step(1'b0, 1'b0, 10'h0, 32'h0);
        release dut.cycle_cnt;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'hFFFFFFFF) $display("FAIL cnt_max: got %h want ffffffff", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL cnt_wrap: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL cnt_after_wrap: got %h want 00000001", rdata); else pass_cnt++;
        step(1'b1, 1'b1, IO_CLR, 32'hDEADBEEF);
        total++; if (rdata !== 32'h0) $display("FAIL clr_wo: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL cnt_clr: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL cnt_clr_inc: got %h want 00000001", rdata); else pass_cnt++;
    endtask

    task automatic test_unmapped();
        step(1'b1, 1'b0, 10'h3FC, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL unmapped_rd: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b0, 1'b1, IO_SW, 32'hFFFFFFFF);
        step(1'b0, 1'b1, 10'h3FC, 32'hFFFFFFFF);
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h1) $display("FAIL ro_write_sw: got %h want 00000001", rdata); else pass_cnt++;
        total++; if (led_out !== 24'h123456) $display("FAIL ro_write_led: got %h want 123456", led_out); else pass_cnt++;
        step(1'b0, 1'b0, IO_LED, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL no_read: got %h want 00000000", rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, IO_LED, 32'h00FFFFFF);
        step(1'b0, 1'b0, 10'h0, 32'h0);
        total++; if (led_out !== 24'hFFFFFF) $display("FAIL mid_led_set: got %h want ffffff", led_out); else pass_cnt++;
        button_in = 1'b0;
        repeat (8) step(1'b0, 1'b0, 10'h0, 32'h0);
        button_in = 1'b1;
        repeat (7) step(1'b0, 1'b0, 10'h0, 32'h0);
        button_in = 1'b0;
        switch_in = 24'h3;
        repeat (4) step(1'b0, 1'b0, 10'h0, 32'h0);
        reset = 1'b1;
        step(1'b1, 1'b0, IO_CNT, 32'h0);
        reset = 1'b0;
        total++; if (led_out !== 24'h0) $display("FAIL mid_rst_led: got %h want 000000", led_out); else pass_cnt++;
        total++; if (rdata !== 32'h0) $display("FAIL mid_rst_cnt: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_BTN, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL mid_rst_flag: got %h want 00000000", rdata); else pass_cnt++;
        repeat (3) step(1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h0) $display("FAIL mid_deb_early: got %h want 00000000", rdata); else pass_cnt++;
        step(1'b1, 1'b0, IO_SW, 32'h0);
        total++; if (rdata !== 32'h3) $display("FAIL mid_deb_done: got %h want 00000003", rdata); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; IORead = 1'b0; IOWrite = 1'b0; addr_low = '0; wdata = '0;
        switch_in = '0; button_in = 1'b0;
        test_reset();
        test_led();
        test_rw_same();
        test_switch();
        test_button();
        test_counter();
        test_unmapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
